// File: rtl/mdu_pkg.sv
// rtl/mdu_pkg.sv - MDU opcode encodings, operand signedness helpers and conditioned-operation record
package mdu_pkg;

  localparam int PAR_W = 32;
  localparam int OPC_W = 3;

  localparam logic [OPC_W-1:0] MUL    = 3'b000;
  localparam logic [OPC_W-1:0] MULH   = 3'b001;
  localparam logic [OPC_W-1:0] MULHSU = 3'b010;
  localparam logic [OPC_W-1:0] MULHU  = 3'b011;
  localparam logic [OPC_W-1:0] DIV    = 3'b100;
  localparam logic [OPC_W-1:0] DIVU   = 3'b101;
  localparam logic [OPC_W-1:0] REM    = 3'b110;
  localparam logic [OPC_W-1:0] REMU   = 3'b111;

  typedef struct packed {
    logic [PAR_W:0]   op0;
    logic [PAR_W:0]   op1;
    logic [OPC_W-1:0] opCode;
    logic             divByZero;
    logic             divOverflow;
    logic             negQuot;
    logic             negRem;
  } condOp_t;

  function automatic logic isDiv(input logic [OPC_W-1:0] op);
    return !(op inside {MUL, MULH, MULHSU, MULHU});
  endfunction

  function automatic logic op0Unsigned(input logic [OPC_W-1:0] op);
    return op inside {DIVU, REMU, MULHSU, MULHU};
  endfunction

  function automatic logic op1Unsigned(input logic [OPC_W-1:0] op);
    return op inside {DIVU, REMU, MULHU};
  endfunction

  // Zero-extended absolute value; MIN maps to 2^(PAR_W-1), which fits in PAR_W+1 bits.
  function automatic logic [PAR_W:0] magnitude(input logic [PAR_W-1:0] v);
    return {1'b0, v[PAR_W-1] ? (~v + 1'b1) : v};
  endfunction

endpackage

// File: rtl/operand_cond_logic.sv
// rtl/operand_cond_logic.sv - combinational operand widening and division special-case flags
// Optional: MDU_OPERAND_MAGNITUDE_EN replaces signed division operands with their magnitudes.
module operand_cond_logic
  import mdu_pkg::*;
(
  input  logic [PAR_W-1:0] op0_in,
  input  logic [PAR_W-1:0] op1_in,
  input  logic [OPC_W-1:0] op_code,
  output condOp_t          cond_out
);

  logic           div;
  logic           signed_div;
  logic           op0_zero;
  logic [PAR_W:0] op0_ext;
  logic [PAR_W:0] op1_ext;

  always_comb begin
    div        = isDiv(op_code);
    signed_div = div && !op0Unsigned(op_code);
    op0_zero   = (op0_in == '0);
    op0_ext    = op0Unsigned(op_code) ? {1'b0, op0_in} : {op0_in[PAR_W-1], op0_in};
    op1_ext    = op1Unsigned(op_code) ? {1'b0, op1_in} : {op1_in[PAR_W-1], op1_in};
`ifdef MDU_OPERAND_MAGNITUDE_EN
    if (signed_div) begin
      op0_ext = magnitude(op0_in);
      op1_ext = magnitude(op1_in);
    end
`endif
    cond_out             = '0;
    cond_out.op0         = op0_ext;
    cond_out.op1         = op1_ext;
    cond_out.opCode      = op_code;
    cond_out.divByZero   = div && op0_zero;
    cond_out.divOverflow = signed_div && (op1_in == {1'b1, {(PAR_W-1){1'b0}}}) && (op0_in == '1);
    cond_out.negQuot     = signed_div && (op0_in[PAR_W-1] ^ op1_in[PAR_W-1]) && !op0_zero;
    cond_out.negRem      = signed_div && op1_in[PAR_W-1];
  end

endmodule

// File: rtl/operand_cond_stage.sv
// rtl/operand_cond_stage.sv - registered MDU operand conditioning behind a 2-entry skid buffer
// Optional: MDU_OPERAND_MAGNITUDE_EN (see operand_cond_logic). PAR/OPCODE_WIDTH must match mdu_pkg.
module operand_cond_stage
  import mdu_pkg::*;
#(
  parameter int PAR          = PAR_W,
  parameter int OPCODE_WIDTH = OPC_W
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    flush,
  input  logic                    inValid,
  output logic                    inReady,
  input  logic [OPCODE_WIDTH-1:0] opCode,
  input  logic [PAR-1:0]          op0In,
  input  logic [PAR-1:0]          op1In,
  output logic                    outValid,
  input  logic                    outReady,
  output logic [PAR:0]            op0Out,
  output logic [PAR:0]            op1Out,
  output logic [OPCODE_WIDTH-1:0] opCodeOut,
  output logic                    divByZero,
  output logic                    divOverflow,
  output logic                    negQuot,
  output logic                    negRem
);

  typedef enum logic [1:0] {EMPTY, ONE, FULL} buf_state_t;

  buf_state_t state_q, state_d;
  condOp_t    head_q, head_d;
  condOp_t    skid_q, skid_d;
  condOp_t    cond;
  logic       in_ready_q, in_ready_d;
  logic       out_valid_q, out_valid_d;
  logic       accept, retire;

  operand_cond_logic u_cond (
    .op0_in   (op0In),
    .op1_in   (op1In),
    .op_code  (opCode),
    .cond_out (cond)
  );

  always_comb begin
    accept  = inValid && in_ready_q;
    retire  = out_valid_q && outReady;
    state_d = state_q;
    head_d  = head_q;
    skid_d  = skid_q;
    if (flush) begin
      state_d = EMPTY;
    end else begin
      case (state_q)
        EMPTY: if (accept) begin
          head_d  = cond;
          state_d = ONE;
        end
        ONE: begin
          if (accept && retire) begin
            head_d = cond;
          end else if (accept) begin
            skid_d  = cond;
            state_d = FULL;
          end else if (retire) begin
            state_d = EMPTY;
          end
        end
        FULL: if (retire) begin
          head_d  = skid_q;
          state_d = ONE;
        end
        default: state_d = EMPTY;
      endcase
    end
    // Handshake outputs are registered from the next state, so neither depends on outReady.
    in_ready_d  = (state_d != FULL);
    out_valid_d = (state_d != EMPTY);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= EMPTY;
      head_q      <= '0;
      skid_q      <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      head_q      <= head_d;
      skid_q      <= skid_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign inReady     = in_ready_q;
  assign outValid    = out_valid_q;
  assign op0Out      = head_q.op0;
  assign op1Out      = head_q.op1;
  assign opCodeOut   = head_q.opCode;
  assign divByZero   = head_q.divByZero;
  assign divOverflow = head_q.divOverflow;
  assign negQuot     = head_q.negQuot;
  assign negRem      = head_q.negRem;

endmodule
